pll_clock_supervisor: RTL and testbench

//   Sequences and supervises an N-output fabric PLL from its reference clock domain.
//   - Drives the PLL reset and qualifies its asynchronous lock flag.
//   - Releases one reset per output-clock channel in a staggered order.
//   - On loss of lock, re-asserts every channel reset and re-runs the bring-up.
//   - Retries the PLL on lock timeout and counts lock-loss events.

---
 rtl/pll_clock_supervisor.sv | 151 +++++++++++++++
 tb/tb_pll_clock_supervisor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pll_clock_supervisor.sv
// Brings up a multi-output PLL from its reference clock: pulses the PLL reset,
// qualifies lock, then releases per-channel resets in a staggered order.
module pll_clock_supervisor #(
  parameter int unsigned NUM_CLOCKS         = 2,
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned SEQ_GAP            = 8,
  parameter int unsigned CNT_W              = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] chan_rst,
  output logic                  all_ready,
  output logic [2:0]            state,
  output logic [CNT_W-1:0]      lock_loss_cnt
);

  localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(SEQ_GAP + 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    SEQUENCE  = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync_q, lk_q;
  logic [RST_W-1:0]        rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [STB_W-1:0]        stb_cnt_q, stb_cnt_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [NUM_CLOCKS-1:0]   chan_rst_d;
  logic [CNT_W-1:0]        loss_cnt_d;
  logic                    pll_rst_d, all_ready_d, lost;

  assign state = 3'(state_q);

  // Next-state, counters and registered-output values
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    to_cnt_d   = to_cnt_q;
    stb_cnt_d  = stb_cnt_q;
    gap_d      = gap_q;
    chan_rst_d = chan_rst;
    loss_cnt_d = lock_loss_cnt;
    lost       = 1'b0;

    case (state_q)
      RESET_PLL: begin
        if (rst_cnt_q == RST_W'(PLL_RST_CYCLES - 1)) begin
          state_d  = WAIT_LOCK;
          to_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lk_q) begin
          state_d   = STABLE;
          stb_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_d   = RESET_PLL;
          rst_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      STABLE: begin
        if (!lk_q) begin
          state_d  = WAIT_LOCK;
          to_cnt_d = '0;
        end else if (stb_cnt_q == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = SEQUENCE;
          gap_d   = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
        end
      end
      SEQUENCE: begin
        if (!lk_q) begin
          lost = 1'b1;
        end else if (chan_rst == '0) begin
          state_d = RUN;
        end else if (gap_q == '0) begin
          // Clearing the lowest set bit releases channels 0,1,2,... in order
          chan_rst_d = chan_rst & (chan_rst - NUM_CLOCKS'(1));
          gap_d      = GAP_W'(SEQ_GAP - 1);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      RUN: begin
        if (!lk_q) lost = 1'b1;
      end
      default: begin
        state_d = RESET_PLL;
      end
    endcase

    if (lost && (lock_loss_cnt != '1)) loss_cnt_d = lock_loss_cnt + CNT_W'(1);

    // Lock loss and restart both force a full re-bring-up
    if (lost || restart) begin
      state_d    = RESET_PLL;
      rst_cnt_d  = '0;
      chan_rst_d = '1;
    end

    pll_rst_d   = (state_d == RESET_PLL);
    all_ready_d = (state_d == RUN);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q        <= 1'b0;
      lk_q          <= 1'b0;
      state_q       <= RESET_PLL;
      rst_cnt_q     <= '0;
      to_cnt_q      <= '0;
      stb_cnt_q     <= '0;
      gap_q         <= '0;
      chan_rst      <= '1;
      pll_rst       <= 1'b1;
      all_ready     <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      sync_q        <= pll_locked;
      lk_q          <= sync_q;
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      to_cnt_q      <= to_cnt_d;
      stb_cnt_q     <= stb_cnt_d;
      gap_q         <= gap_d;
      chan_rst      <= chan_rst_d;
      pll_rst       <= pll_rst_d;
      all_ready     <= all_ready_d;
      lock_loss_cnt <= loss_cnt_d;
    end
  end

endmodule

// File: tb/tb_pll_clock_supervisor.sv
// Self-checking bench for pll_clock_supervisor: vector table for bring-up plus
// directed sequences for retry, lock glitches, lock loss, restart and reset.
module tb_pll_clock_supervisor;

  logic       refclk = 1'b0;
  logic       rst, restart, pll_locked;
  logic       pll_rst, all_ready;
  logic [2:0] chan_rst;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  pll_clock_supervisor #(
    .NUM_CLOCKS(3), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT(32), .SEQ_GAP(2), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst(rst), .restart(restart), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .chan_rst(chan_rst), .all_ready(all_ready),
    .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    string      name;
    logic       pr;
    logic [2:0] cr;
    logic       ar;
    logic [2:0] st;
    logic [7:0] lc;
  } exp_t;

  typedef struct {
    int unsigned cycles;
    logic        locked;
    logic        pr;
    logic [2:0]  cr;
    logic        ar;
    logic [2:0]  st;
    logic [7:0]  lc;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic push_exp(input string nm, input logic pr, input logic [2:0] cr,
                          input logic ar, input logic [2:0] st, input logic [7:0] lc);
    exp_t e;
    e.name = nm; e.pr = pr; e.cr = cr; e.ar = ar; e.st = st; e.lc = lc;
    sb_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard: no expectation queued");
      return;
    end
    e = sb_q.pop_front();
    if (pll_rst !== e.pr || chan_rst !== e.cr || all_ready !== e.ar ||
        state !== e.st || lock_loss_cnt !== e.lc) begin
      n_fail++;
      $display("FAIL %s @%0t: got pll_rst=%b chan_rst=%b all_ready=%b state=%0d cnt=%0d, want pll_rst=%b chan_rst=%b all_ready=%b state=%0d cnt=%0d",
               e.name, $time, pll_rst, chan_rst, all_ready, state, lock_loss_cnt,
               e.pr, e.cr, e.ar, e.st, e.lc);
    end
  endtask

  task automatic expect_after(input int unsigned n, input string nm, input logic pr,
                              input logic [2:0] cr, input logic ar, input logic [2:0] st,
                              input logic [7:0] lc);
    push_exp(nm, pr, cr, ar, st, lc);
    step(n);
    check_pop();
  endtask

  // Leaves the bench in cycle 0, the first cycle after rst is released
  task automatic do_reset(input logic locked);
    rst = 1'b1; restart = 1'b0; pll_locked = locked;
    step(2);
    rst = 1'b0;
  endtask

  task automatic bring_up();
    do_reset(1'b0);
    step(10);
    pll_locked = 1'b1;
    step(17);
  endtask

  vec_t tbl[13];
  int   exp_cnt;
  logic pr;

  initial begin
    tbl[0]  = '{0, 1'b0, 1'b1, 3'b111, 1'b0, 3'd0, 8'd0};
    tbl[1]  = '{3, 1'b0, 1'b1, 3'b111, 1'b0, 3'd0, 8'd0};
    tbl[2]  = '{1, 1'b0, 1'b0, 3'b111, 1'b0, 3'd1, 8'd0};
    tbl[3]  = '{6, 1'b0, 1'b0, 3'b111, 1'b0, 3'd1, 8'd0};
    tbl[4]  = '{2, 1'b1, 1'b0, 3'b111, 1'b0, 3'd1, 8'd0};
    tbl[5]  = '{1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2, 8'd0};
    tbl[6]  = '{7, 1'b1, 1'b0, 3'b111, 1'b0, 3'd2, 8'd0};
    tbl[7]  = '{1, 1'b1, 1'b0, 3'b111, 1'b0, 3'd3, 8'd0};
    tbl[8]  = '{1, 1'b1, 1'b0, 3'b110, 1'b0, 3'd3, 8'd0};
    tbl[9]  = '{1, 1'b1, 1'b0, 3'b110, 1'b0, 3'd3, 8'd0};
    tbl[10] = '{1, 1'b1, 1'b0, 3'b100, 1'b0, 3'd3, 8'd0};
    tbl[11] = '{2, 1'b1, 1'b0, 3'b000, 1'b0, 3'd3, 8'd0};
    tbl[12] = '{1, 1'b1, 1'b0, 3'b000, 1'b1, 3'd4, 8'd0};

    // Bring-up with lock arriving in cycle 10
    do_reset(1'b0);
    for (int i = 0; i < 13; i++) begin
      pll_locked = tbl[i].locked;
      expect_after(tbl[i].cycles, $sformatf("bringup_vec%0d", i), tbl[i].pr,
                   tbl[i].cr, tbl[i].ar, tbl[i].st, tbl[i].lc);
    end

    // Repeated lock loss from RUN; counter saturates at 255
    for (int i = 1; i <= 300; i++) begin
      exp_cnt = (i - 1 > 255) ? 255 : i - 1;
      pll_locked = 1'b0;
      expect_after(1, "loss_still_run", 1'b0, 3'b000, 1'b1, 3'd4, 8'(exp_cnt));
      exp_cnt = (i > 255) ? 255 : i;
      expect_after(2, "loss_reset", 1'b1, 3'b111, 1'b0, 3'd0, 8'(exp_cnt));
      pll_locked = 1'b1;
      expect_after(19, "loss_rerun", 1'b0, 3'b000, 1'b1, 3'd4, 8'(exp_cnt));
    end

    // Lock never arrives: 4-cycle PLL reset every 36 cycles
    do_reset(1'b0);
    for (int c = 0; c < 80; c++) begin
      pr = ((c % 36) < 4);
      expect_after((c == 0) ? 0 : 1, $sformatf("retry_c%0d", c), pr, 3'b111, 1'b0,
                   pr ? 3'd0 : 3'd1, 8'd0);
    end

    // One-cycle lock glitch in STABLE restarts the stability count
    do_reset(1'b0);
    step(10);
    pll_locked = 1'b1;
    step(6);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    expect_after(1, "glitch_stable", 1'b0, 3'b111, 1'b0, 3'd2, 8'd0);
    expect_after(1, "glitch_wait", 1'b0, 3'b111, 1'b0, 3'd1, 8'd0);
    expect_after(1, "glitch_restable", 1'b0, 3'b111, 1'b0, 3'd2, 8'd0);
    expect_after(7, "glitch_still_stable", 1'b0, 3'b111, 1'b0, 3'd2, 8'd0);
    expect_after(1, "glitch_seq", 1'b0, 3'b111, 1'b0, 3'd3, 8'd0);

    // Restart in RUN with steady lock
    bring_up();
    expect_after(0, "restart_pre_run", 1'b0, 3'b000, 1'b1, 3'd4, 8'd0);
    restart = 1'b1;
    expect_after(1, "restart_reset", 1'b1, 3'b111, 1'b0, 3'd0, 8'd0);
    restart = 1'b0;
    expect_after(4, "restart_wait", 1'b0, 3'b111, 1'b0, 3'd1, 8'd0);
    expect_after(9, "restart_seq", 1'b0, 3'b111, 1'b0, 3'd3, 8'd0);
    expect_after(6, "restart_run", 1'b0, 3'b000, 1'b1, 3'd4, 8'd0);

    // Restart coincident with a lock loss still counts the loss once
    pll_locked = 1'b0;
    step(2);
    restart = 1'b1;
    expect_after(1, "restart_loss", 1'b1, 3'b111, 1'b0, 3'd0, 8'd1);
    restart = 1'b0;
    pll_locked = 1'b1;
    expect_after(1, "restart_loss_hold", 1'b1, 3'b111, 1'b0, 3'd0, 8'd1);

    // rst in the middle of SEQUENCE
    expect_after(15, "midseq_pre", 1'b0, 3'b100, 1'b0, 3'd3, 8'd1);
    rst = 1'b1;
    expect_after(1, "midseq_rst", 1'b1, 3'b111, 1'b0, 3'd0, 8'd0);
    rst = 1'b0;
    expect_after(4, "midseq_wait", 1'b0, 3'b111, 1'b0, 3'd1, 8'd0);
    expect_after(9, "midseq_seq", 1'b0, 3'b111, 1'b0, 3'd3, 8'd0);
    expect_after(1, "midseq_ch0", 1'b0, 3'b110, 1'b0, 3'd3, 8'd0);
    expect_after(5, "midseq_run", 1'b0, 3'b000, 1'b1, 3'd4, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
